// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: scanout line prefetch (priority) and a req/ack drawing writer share one memory port.
// Optional VGA_FB_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module vga_fb_arbiter #(
   parameter int          ADDR_W    = 20,
   parameter int          DATA_W    = 24,
   parameter int          H_VISIBLE = 1024,
   parameter int          V_VISIBLE = 768,
   parameter int          LB_AW     = 10,
   parameter int          BURST_LEN = 16,
   parameter int unsigned FB_BASE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              line_req,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lb_we,
   output logic [LB_AW-1:0]  lb_addr,
   output logic [DATA_W-1:0] lb_data,
   output logic              fetch_busy,
   output logic              line_done,
`ifdef VGA_FB_UNDERRUN_CNT_EN
   output logic [15:0]       underrun_cnt,
`endif
   output logic              underrun
);

   localparam int CW = $clog2(H_VISIBLE + 1);
   localparam int RW = $clog2(V_VISIBLE + 1);
   localparam int BW = $clog2(BURST_LEN + 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_FETCH_RD  = 2'd1;
   localparam logic [1:0] S_FETCH_WR  = 2'd2;
   localparam logic [1:0] S_WAIT_DATA = 2'd3;

   logic [1:0]        state;
   logic [RW-1:0]     row;
   logic [ADDR_W-1:0] row_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [CW-1:0]     rd_cnt;
   logic [CW-1:0]     rx_cnt;
   logic [BW-1:0]     burst_cnt;
   logic              pending;
   logic              wr_stall;
   logic              final_slot;

   logic              wr_present;
   logic              rd_present;
   logic              rd_acc;
   logic              wr_acc;
   logic              rd_last;
   logic              burst_end;
   logic              rx_ok;
   logic              rx_last;
   logic [RW-1:0]     row_eff;
   logic [ADDR_W-1:0] addr_eff;
   logic              line_acc;

   // A write already stalled on the bus keeps the port so the command stays stable.
   always_comb begin
      wr_present = 1'b0;
      case (state)
         S_IDLE:      wr_present = wr_req && (!pending || wr_stall);
         S_WAIT_DATA: wr_present = wr_req;
         S_FETCH_WR:  wr_present = 1'b1;
         default:     wr_present = 1'b0;
      endcase
      rd_present = (state == S_FETCH_RD);
      mem_valid  = wr_present | rd_present;
      mem_we     = wr_present;
      mem_addr   = wr_present ? wr_addr : (rd_present ? rd_addr : '0);
      mem_wdata  = wr_present ? wr_data : '0;
      rd_acc     = rd_present && mem_ready;
      wr_acc     = wr_present && mem_ready;
      wr_ack     = wr_acc;
      rd_last    = (rd_cnt == CW'(H_VISIBLE - 1));
      burst_end  = (burst_cnt == BW'(BURST_LEN - 1));
      rx_ok      = mem_rvalid && (rx_cnt < rd_cnt);
      rx_last    = (rx_cnt == CW'(H_VISIBLE - 1));
      row_eff    = frame_start ? '0 : row;
      addr_eff   = frame_start ? ADDR_W'(FB_BASE) : row_addr;
      line_acc   = line_req && !fetch_busy && (row_eff < RW'(V_VISIBLE));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         row        <= '0;
         row_addr   <= ADDR_W'(FB_BASE);
         rd_addr    <= '0;
         rd_cnt     <= '0;
         rx_cnt     <= '0;
         burst_cnt  <= '0;
         pending    <= 1'b0;
         wr_stall   <= 1'b0;
         final_slot <= 1'b0;
         fetch_busy <= 1'b0;
         underrun   <= 1'b0;
         lb_we      <= 1'b0;
         lb_addr    <= '0;
         lb_data    <= '0;
         line_done  <= 1'b0;
      end else begin
         if (line_acc) begin
            row        <= row_eff + RW'(1);
            row_addr   <= addr_eff + ADDR_W'(H_VISIBLE);
            rd_addr    <= addr_eff;
            pending    <= 1'b1;
            fetch_busy <= 1'b1;
         end else begin
            if (frame_start) begin
               row      <= '0;
               row_addr <= ADDR_W'(FB_BASE);
            end
            if (line_done)
               fetch_busy <= 1'b0;
         end
         underrun <= line_req && fetch_busy;
         wr_stall <= wr_present && !mem_ready;

         lb_we     <= rx_ok;
         line_done <= rx_ok && rx_last;
         if (rx_ok) begin
            lb_data <= mem_rdata;
            lb_addr <= LB_AW'(rx_cnt);
            rx_cnt  <= rx_cnt + CW'(1);
         end

         case (state)
            S_IDLE: begin
               if (pending && !wr_stall) begin
                  state     <= S_FETCH_RD;
                  pending   <= 1'b0;
                  rd_cnt    <= '0;
                  rx_cnt    <= '0;
                  burst_cnt <= '0;
               end
            end
            S_FETCH_RD: begin
               if (rd_acc) begin
                  rd_addr   <= rd_addr + ADDR_W'(1);
                  rd_cnt    <= rd_cnt + CW'(1);
                  burst_cnt <= burst_end ? '0 : burst_cnt + BW'(1);
                  if (burst_end && wr_req) begin
                     state      <= S_FETCH_WR;
                     final_slot <= rd_last;
                  end else if (rd_last) begin
                     state <= S_WAIT_DATA;
                  end
               end
            end
            S_FETCH_WR: begin
               // A slot after the final read may finish after all data is already in.
               if (wr_acc) begin
                  if (!final_slot)
                     state <= S_FETCH_RD;
                  else if (rx_cnt == CW'(H_VISIBLE))
                     state <= S_IDLE;
                  else
                     state <= S_WAIT_DATA;
               end
            end
            default: begin
               if (line_done)
                  state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef VGA_FB_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         underrun_cnt <= '0;
      else if (underrun && underrun_cnt != 16'hFFFF)
         underrun_cnt <= underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: random memory contents with a latency-2 responder, scenario tasks
// checking command streams and line buffer writes against an expected-sequence model.
module tb_vga_fb_arbiter;

   localparam int AW  = 20;
   localparam int DW  = 24;
   localparam int H   = 8;
   localparam int V   = 3;
   localparam int BL  = 4;
   localparam int LBW = 3;
   localparam logic [AW-1:0] BASE = 20'h100;
   localparam int CMW = 1 + AW + DW;
   localparam int LBE = 1 + LBW + DW;

   logic          clk, rst, frame_start, line_req, wr_req, wr_ack;
   logic [AW-1:0] wr_addr, mem_addr;
   logic [DW-1:0] wr_data, mem_wdata, mem_rdata, lb_data;
   logic          mem_valid, mem_we, mem_ready, mem_rvalid, lb_we;
   logic [LBW-1:0] lb_addr;
   logic          fetch_busy, line_done, underrun;
`ifdef VGA_FB_UNDERRUN_CNT_EN
   logic [15:0]   underrun_cnt;
`endif

   vga_fb_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .H_VISIBLE(H), .V_VISIBLE(V),
      .LB_AW(LBW), .BURST_LEN(BL), .FB_BASE(32'h100)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .line_req(line_req),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
      .fetch_busy(fetch_busy), .line_done(line_done),
`ifdef VGA_FB_UNDERRUN_CNT_EN
      .underrun_cnt(underrun_cnt),
`endif
      .underrun(underrun)
   );

   int vectors = 0;
   int fails   = 0;
   int cyc     = 0;
   int n_done  = 0;
   int n_ack   = 0;
   int n_under = 0;
   int stab_err = 0;
   int done_cyc = 0;
   int fall_cyc = 0;

   logic [CMW-1:0] cmd_q[$], exp_cmd_q[$];
   logic [LBE-1:0] lb_q[$], exp_lb_q[$];
   logic [DW-1:0]  mem_img[logic [AW-1:0]];
   int             ret_due[$];
   logic [AW-1:0]  ret_addr[$];

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1);
   end

   // memory responder and bus monitor, both on the falling edge
   initial begin
      logic [CMW+1-1:0] cur, p_cmd;
      logic p_stall, p_busy;
      p_stall = 1'b0;
      p_busy  = 1'b0;
      p_cmd   = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (ret_due.size() != 0 && ret_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_img[ret_addr[0]];
            void'(ret_due.pop_front());
            void'(ret_addr.pop_front());
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = DW'($urandom);
         end
         cur = {mem_valid, mem_we, mem_addr, mem_wdata};
         if (!rst && p_stall && cur !== p_cmd) stab_err++;
         p_stall = !rst && mem_valid && !mem_ready;
         p_cmd   = cur;
         if (!rst && mem_valid && mem_ready) begin
            cmd_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : DW'(0)});
            if (!mem_we) begin
               if (!mem_img.exists(mem_addr)) mem_img[mem_addr] = DW'($urandom);
               ret_due.push_back(cyc + 2);
               ret_addr.push_back(mem_addr);
            end
         end
         if (wr_ack) n_ack++;
         if (underrun) n_under++;
         if (lb_we) lb_q.push_back({line_done, lb_addr, lb_data});
         if (line_done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (p_busy && !fetch_busy) fall_cyc = cyc;
         p_busy = fetch_busy;
      end
   end

   // expected command stream for one line: sequential reads, one write after wr_after reads
   function automatic void model_line(input logic [AW-1:0] base, input int wr_after,
                                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      exp_cmd_q.delete();
      for (int i = 0; i < H; i++) begin
         exp_cmd_q.push_back({1'b0, base + AW'(i), DW'(0)});
         if (i + 1 == wr_after) exp_cmd_q.push_back({1'b1, wa, wd});
      end
   endfunction

   function automatic void model_lb(input logic [AW-1:0] base);
      logic [AW-1:0] a;
      exp_lb_q.delete();
      for (int i = 0; i < H; i++) begin
         a = base + AW'(i);
         exp_lb_q.push_back({(i == H - 1), LBW'(i), mem_img.exists(a) ? mem_img[a] : {DW{1'bx}}});
      end
   endfunction

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic fs, input logic lr);
      frame_start = fs;
      line_req    = lr;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      line_req    = 1'b0;
   endtask

   task automatic clear_logs();
      cmd_q.delete();
      lb_q.delete();
      n_ack    = 0;
      n_under  = 0;
      stab_err = 0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int start;
      int k;
      start = n_done;
      k = 0;
      while (n_done == start && k < budget) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (n_done == start) begin
         fails++;
         $display("FAIL %s line_done: none within %0d cycles, want 1", tag, budget);
      end
      step(2);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_valid, mem_we, wr_ack, lb_we, fetch_busy, line_done, underrun} !== 7'b0) begin
         fails++;
         $display("FAIL reset ctrl got %b want 0000000",
                  {mem_valid, mem_we, wr_ack, lb_we, fetch_busy, line_done, underrun});
      end
      vectors++;
      if ({mem_addr, mem_wdata, lb_addr, lb_data} !== '0) begin
         fails++;
         $display("FAIL reset buses got %h/%h/%h/%h want 0", mem_addr, mem_wdata, lb_addr, lb_data);
      end
`ifdef VGA_FB_UNDERRUN_CNT_EN
      vectors++;
      if (underrun_cnt !== 16'd0) begin
         fails++;
         $display("FAIL reset underrun_cnt got %0d want 0", underrun_cnt);
      end
`endif
      step(1);
   endtask

   task automatic test_basic_fetch();
      clear_logs();
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      @(negedge clk);
      vectors++;
      if (fetch_busy !== 1'b1) begin
         fails++;
         $display("FAIL basic fetch_busy_rise got %b want 1", fetch_busy);
      end
      wait_done(60, "basic");
      model_line(BASE, -1, '0, '0);
      model_lb(BASE);
      vectors++;
      if (cmd_q.size() != exp_cmd_q.size()) begin
         fails++;
         $display("FAIL basic cmd_count got %0d want %0d", cmd_q.size(), exp_cmd_q.size());
      end
      foreach (exp_cmd_q[i]) if (i < cmd_q.size()) begin
         vectors++;
         if (cmd_q[i] !== exp_cmd_q[i]) begin
            fails++;
            $display("FAIL basic cmd[%0d] got %h want %h", i, cmd_q[i], exp_cmd_q[i]);
         end
      end
      vectors++;
      if (lb_q.size() != exp_lb_q.size()) begin
         fails++;
         $display("FAIL basic lb_count got %0d want %0d", lb_q.size(), exp_lb_q.size());
      end
      foreach (exp_lb_q[i]) if (i < lb_q.size()) begin
         vectors++;
         if (lb_q[i] !== exp_lb_q[i]) begin
            fails++;
            $display("FAIL basic lb[%0d] got %h want %h", i, lb_q[i], exp_lb_q[i]);
         end
      end
      vectors++;
      if (fall_cyc !== done_cyc + 1) begin
         fails++;
         $display("FAIL basic busy_fall cycle got %0d want %0d", fall_cyc, done_cyc + 1);
      end
   endtask

   task automatic test_row_stepping();
      pulse(1'b1, 1'b0);
      for (int r = 0; r < V + 1; r++) begin
         clear_logs();
         pulse(1'b0, 1'b1);
         if (r < V) begin
            wait_done(60, "rows");
            model_line(BASE + AW'(r * H), -1, '0, '0);
            vectors++;
            if (cmd_q.size() != exp_cmd_q.size()) begin
               fails++;
               $display("FAIL rows[%0d] cmd_count got %0d want %0d", r, cmd_q.size(), exp_cmd_q.size());
            end
            foreach (exp_cmd_q[i]) if (i < cmd_q.size()) begin
               vectors++;
               if (cmd_q[i] !== exp_cmd_q[i]) begin
                  fails++;
                  $display("FAIL rows[%0d] cmd[%0d] got %h want %h", r, i, cmd_q[i], exp_cmd_q[i]);
               end
            end
         end else begin
            step(20);
            vectors++;
            if (cmd_q.size() != 0 || n_under != 0 || fetch_busy !== 1'b0) begin
               fails++;
               $display("FAIL rows past_limit got cmds=%0d underruns=%0d busy=%b want 0/0/0",
                        cmd_q.size(), n_under, fetch_busy);
            end
         end
      end
   endtask

   task automatic test_writer_slot();
      int k;
      clear_logs();
      pulse(1'b1, 1'b0);
      wr_addr = 20'h200;
      wr_data = 24'hABCDEF;
      pulse(1'b0, 1'b1);
      wr_req = 1'b1;
      k = 0;
      @(negedge clk);
      while (!wr_ack && k < 40) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      wr_req = 1'b0;
      wait_done(60, "wslot");
      model_line(BASE, BL, 20'h200, 24'hABCDEF);
      model_lb(BASE);
      vectors++;
      if (n_ack != 1) begin
         fails++;
         $display("FAIL wslot ack_count got %0d want 1", n_ack);
      end
      vectors++;
      if (cmd_q.size() != exp_cmd_q.size()) begin
         fails++;
         $display("FAIL wslot cmd_count got %0d want %0d", cmd_q.size(), exp_cmd_q.size());
      end
      foreach (exp_cmd_q[i]) if (i < cmd_q.size()) begin
         vectors++;
         if (cmd_q[i] !== exp_cmd_q[i]) begin
            fails++;
            $display("FAIL wslot cmd[%0d] got %h want %h", i, cmd_q[i], exp_cmd_q[i]);
         end
      end
      foreach (exp_lb_q[i]) begin
         vectors++;
         if (i >= lb_q.size() || lb_q[i] !== exp_lb_q[i]) begin
            fails++;
            $display("FAIL wslot lb[%0d] got %h want %h", i, (i < lb_q.size()) ? lb_q[i] : '0, exp_lb_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int stall_at;
      int k;
      pulse(1'b1, 1'b0);
      for (int ln = 0; ln < 2; ln++) begin
         clear_logs();
         stall_at = $urandom_range(1, 5);
         pulse(1'b0, 1'b1);
         k = 0;
         if (ln == 0) begin
            while (cmd_q.size() < stall_at && k < 40) begin
               step(1);
               k++;
            end
            mem_ready = 1'b0;
            step(3);
            mem_ready = 1'b1;
            wait_done(60, "bp_fixed");
         end else begin
            while (n_done == 0 && k < 200) begin
               mem_ready = 1'($urandom_range(0, 1));
               step(1);
               k++;
               if (lb_q.size() != 0 && lb_q[lb_q.size() - 1][LBE-1]) break;
            end
            mem_ready = 1'b1;
            step(12);
         end
         model_line(BASE + AW'(ln * H), -1, '0, '0);
         model_lb(BASE + AW'(ln * H));
         vectors++;
         if (stab_err != 0) begin
            fails++;
            $display("FAIL bp[%0d] stable_cmd got %0d changes under stall want 0", ln, stab_err);
         end
         vectors++;
         if (cmd_q.size() != exp_cmd_q.size()) begin
            fails++;
            $display("FAIL bp[%0d] cmd_count got %0d want %0d", ln, cmd_q.size(), exp_cmd_q.size());
         end
         foreach (exp_cmd_q[i]) if (i < cmd_q.size()) begin
            vectors++;
            if (cmd_q[i] !== exp_cmd_q[i]) begin
               fails++;
               $display("FAIL bp[%0d] cmd[%0d] got %h want %h", ln, i, cmd_q[i], exp_cmd_q[i]);
            end
         end
         foreach (exp_lb_q[i]) begin
            vectors++;
            if (i >= lb_q.size() || lb_q[i] !== exp_lb_q[i]) begin
               fails++;
               $display("FAIL bp[%0d] lb[%0d] got %h want %h", ln, i, (i < lb_q.size()) ? lb_q[i] : '0, exp_lb_q[i]);
            end
         end
      end
   endtask

   task automatic test_idle_write();
      int n;
      clear_logs();
      n = $urandom_range(1, 4);
      wr_addr   = AW'($urandom);
      wr_data   = DW'($urandom);
      mem_ready = 1'b0;
      wr_req    = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vectors++;
         if (wr_ack !== 1'b0 || mem_valid !== 1'b1) begin
            fails++;
            $display("FAIL idle_wr stalled[%0d] ack/valid got %b/%b want 0/1", i, wr_ack, mem_valid);
         end
         step(1);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({wr_ack, mem_we, mem_addr, mem_wdata} !== {2'b11, wr_addr, wr_data}) begin
         fails++;
         $display("FAIL idle_wr accept got ack=%b we=%b %h/%h want 1/1 %h/%h",
                  wr_ack, mem_we, mem_addr, mem_wdata, wr_addr, wr_data);
      end
      step(1);
      wr_req = 1'b0;
      step(2);
      vectors++;
      if (n_ack != 1 || stab_err != 0) begin
         fails++;
         $display("FAIL idle_wr ack_count/stable got %0d/%0d want 1/0", n_ack, stab_err);
      end
   endtask

   task automatic test_underrun();
      clear_logs();
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      step(3);
      pulse(1'b0, 1'b1);
      @(negedge clk);
      vectors++;
      if (underrun !== 1'b1) begin
         fails++;
         $display("FAIL underrun pulse got %b want 1", underrun);
      end
      wait_done(60, "underrun");
      model_line(BASE, -1, '0, '0);
      vectors++;
      if (n_under != 1 || cmd_q.size() != exp_cmd_q.size()) begin
         fails++;
         $display("FAIL underrun pulses/cmds got %0d/%0d want 1/%0d", n_under, cmd_q.size(), exp_cmd_q.size());
      end
`ifdef VGA_FB_UNDERRUN_CNT_EN
      vectors++;
      if (underrun_cnt !== 16'd1) begin
         fails++;
         $display("FAIL underrun_cnt got %0d want 1", underrun_cnt);
      end
`endif
      clear_logs();
      pulse(1'b1, 1'b1);
      wait_done(60, "restart");
      model_line(BASE, -1, '0, '0);
      foreach (exp_cmd_q[i]) begin
         vectors++;
         if (i >= cmd_q.size() || cmd_q[i] !== exp_cmd_q[i]) begin
            fails++;
            $display("FAIL restart cmd[%0d] got %h want %h", i, (i < cmd_q.size()) ? cmd_q[i] : '0, exp_cmd_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      int k;
      int d0;
      clear_logs();
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      k = 0;
      while (cmd_q.size() < 3 && k < 40) begin
         step(1);
         k++;
      end
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      lb_q.delete();
      d0 = n_done;
      @(negedge clk);
      vectors++;
      if ({mem_valid, mem_we, wr_ack, lb_we, fetch_busy, line_done, underrun} !== 7'b0 ||
          {mem_addr, mem_wdata, lb_addr, lb_data} !== '0) begin
         fails++;
         $display("FAIL rst_mid outputs got %b %h %h %h %h want all 0",
                  {mem_valid, mem_we, wr_ack, lb_we, fetch_busy, line_done, underrun},
                  mem_addr, mem_wdata, lb_addr, lb_data);
      end
      step(6);
      vectors++;
      if (lb_q.size() != 0 || n_done != d0) begin
         fails++;
         $display("FAIL rst_mid late_data got lb_we=%0d line_done=%0d want 0/0", lb_q.size(), n_done - d0);
      end
      clear_logs();
      pulse(1'b1, 1'b1);
      wait_done(60, "rst_refetch");
      model_line(BASE, -1, '0, '0);
      model_lb(BASE);
      foreach (exp_cmd_q[i]) begin
         vectors++;
         if (i >= cmd_q.size() || cmd_q[i] !== exp_cmd_q[i]) begin
            fails++;
            $display("FAIL rst_refetch cmd[%0d] got %h want %h", i, (i < cmd_q.size()) ? cmd_q[i] : '0, exp_cmd_q[i]);
         end
      end
      foreach (exp_lb_q[i]) begin
         vectors++;
         if (i >= lb_q.size() || lb_q[i] !== exp_lb_q[i]) begin
            fails++;
            $display("FAIL rst_refetch lb[%0d] got %h want %h", i, (i < lb_q.size()) ? lb_q[i] : '0, exp_lb_q[i]);
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      frame_start = 1'b0;
      line_req    = 1'b0;
      wr_req      = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      mem_ready   = 1'b1;
      test_reset();
      test_basic_fetch();
      test_row_stepping();
      test_writer_slot();
      test_backpressure();
      test_idle_write();
      test_underrun();
      test_reset_mid_fetch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
